// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and request decoding for the Clause-22 MDIO master.
// Clause-45 frames are accepted only when MDIO_CLAUSE45_EN is defined.
package mdio_pkg;

    localparam int FRAME_W = 32;
    localparam int RD_W    = 16;
    localparam int TA_BIT  = 17;
    localparam int RD_MSB  = 15;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    localparam logic [1:0] OP_C22_WRITE    = 2'b01;
    localparam logic [1:0] OP_C22_READ     = 2'b10;
    localparam logic [1:0] OP_C45_ADDR     = 2'b00;
    localparam logic [1:0] OP_C45_WRITE    = 2'b01;
    localparam logic [1:0] OP_C45_READ     = 2'b11;
    localparam logic [1:0] OP_C45_READ_INC = 2'b10;

`ifdef MDIO_CLAUSE45_EN
    localparam bit C45_EN = 1'b1;
`else
    localparam bit C45_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        FRAME    = 2'd2,
        DONE     = 2'd3
    } state_t;

    function automatic logic frame_legal(input logic [1:0] st, input logic [1:0] op);
        logic c22;
        logic c45;
        c22 = (st == ST_C22) && ((op == OP_C22_WRITE) || (op == OP_C22_READ));
        c45 = C45_EN && (st == ST_C45) &&
              ((op == OP_C45_ADDR) || (op == OP_C45_WRITE) ||
               (op == OP_C45_READ) || (op == OP_C45_READ_INC));
        return c22 || c45;
    endfunction

    // Read timing releases the pad from the turnaround bit onward.
    function automatic logic frame_is_read(input logic [1:0] st, input logic [1:0] op);
        logic c22;
        logic c45;
        c22 = (st == ST_C22) && (op == OP_C22_READ);
        c45 = C45_EN && (st == ST_C45) && ((op == OP_C45_READ) || (op == OP_C45_READ_INC));
        return c22 || c45;
    endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: MDC_DIV clk low, MDC_DIV clk high, with strobes flagging the edge on
// which mdc rises or falls. Held low with the divider cleared whenever en is low.
module mdio_mdc_gen #(
    parameter int MDC_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int            DW       = $clog2(MDC_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(MDC_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          phase_end;

    assign phase_end = en && (div_cnt == DIV_LAST);
    assign rise_stb  = phase_end && !mdc;
    assign fall_stb  = phase_end && mdc;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div_cnt <= '0;
            mdc     <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            mdc     <= ~mdc;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/mdio_master_gen.sv
// MDIO management master: preamble, then one 32-bit frame MSB first, with read-data capture.
// Clause-45 requests are legal only when MDIO_CLAUSE45_EN is defined (see mdio_pkg).
module mdio_master_gen
    import mdio_pkg::*;
#(
    parameter int MDC_DIV      = 2,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mdio_start,
    input  logic [31:0]     t_data,
    input  logic            mdio_in,
    output logic            mdc,
    output logic            mdio_out,
    output logic            mdio_oe,
    output logic [RD_W-1:0] rd_data,
    output logic            data_rdy,
    output logic            done,
    output logic            err,
    output logic            busy
);

    localparam int            CW_PRE     = $clog2(PREAMBLE_LEN + 1);
    localparam int            CW         = (CW_PRE > 6) ? CW_PRE : 6;
    localparam logic [CW-1:0] PRE_LAST   = CW'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_W - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     bit_cnt, bit_cnt_nx;
    logic [FRAME_W-1:0] shadow;
    logic              is_read;
    logic [RD_W-1:0]   shift_in;
    logic              accept, req_legal, mdc_en, rise_stb, fall_stb;

    assign req_legal = frame_legal(t_data[31:30], t_data[29:28]);
    assign accept    = (state == IDLE) && mdio_start;
    assign mdc_en    = (state == PREAMBLE) || (state == FRAME);

    mdio_mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (mdc_en),
        .mdc      (mdc),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_nx;
            bit_cnt <= bit_cnt_nx;
        end
    end

    // bit_cnt counts remaining preamble bits, then doubles as the frame bit index.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        mdio_out   = 1'b0;
        mdio_oe    = 1'b0;
        done       = 1'b0;
        data_rdy   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept && req_legal) begin
                    if (PREAMBLE_LEN == 0) begin
                        state_nx   = FRAME;
                        bit_cnt_nx = FRAME_LAST;
                    end else begin
                        state_nx   = PREAMBLE;
                        bit_cnt_nx = PRE_LAST;
                    end
                end
            end
            PREAMBLE: begin
                mdio_oe  = 1'b1;
                mdio_out = 1'b1;
                if (fall_stb) begin
                    if (bit_cnt == '0) begin
                        state_nx   = FRAME;
                        bit_cnt_nx = FRAME_LAST;
                    end else begin
                        bit_cnt_nx = bit_cnt - CW'(1);
                    end
                end
            end
            FRAME: begin
                mdio_oe  = !is_read || (bit_cnt > CW'(TA_BIT));
                mdio_out = mdio_oe && shadow[bit_cnt[4:0]];
                if (fall_stb) begin
                    if (bit_cnt == '0) begin
                        state_nx = DONE;
                    end else begin
                        bit_cnt_nx = bit_cnt - CW'(1);
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                data_rdy = is_read;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data is shifted in on mdc rising edges and published as DONE is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow   <= '0;
            is_read  <= 1'b0;
            shift_in <= '0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            err <= accept && !req_legal;
            if (accept) begin
                shadow  <= t_data;
                is_read <= frame_is_read(t_data[31:30], t_data[29:28]);
            end
            if ((state == FRAME) && rise_stb && (bit_cnt <= CW'(RD_MSB))) begin
                shift_in <= {shift_in[RD_W-2:0], mdio_in};
            end
            if ((state == FRAME) && fall_stb && (bit_cnt == '0) && is_read) begin
                rd_data <= shift_in;
            end
        end
    end

endmodule

// File: tb/tb_mdio_master_gen.sv
// Directed bench for mdio_master_gen: instance A uses MDC_DIV=2/PREAMBLE_LEN=32,
// instance B uses MDC_DIV=1/PREAMBLE_LEN=0; expected waveforms come from a cycle model.
module tb_mdio_master_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [31:0] t_data = '0;
    logic        mdio_in = 1'b1;
    logic        sel = 1'b0;

    logic        mdc_a, out_a, oe_a, rdy_a, done_a, err_a, busy_a;
    logic        mdc_b, out_b, oe_b, rdy_b, done_b, err_b, busy_b;
    logic [15:0] rd_a, rd_b;

    logic        o_mdc, o_out, o_oe, o_rdy, o_done, o_err, o_busy;
    logic [15:0] o_rd;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mdio_master_gen #(.MDC_DIV(2), .PREAMBLE_LEN(32)) dut_a (
        .clk(clk), .reset(reset), .mdio_start(start_a), .t_data(t_data), .mdio_in(mdio_in),
        .mdc(mdc_a), .mdio_out(out_a), .mdio_oe(oe_a), .rd_data(rd_a), .data_rdy(rdy_a),
        .done(done_a), .err(err_a), .busy(busy_a)
    );

    mdio_master_gen #(.MDC_DIV(1), .PREAMBLE_LEN(0)) dut_b (
        .clk(clk), .reset(reset), .mdio_start(start_b), .t_data(t_data), .mdio_in(mdio_in),
        .mdc(mdc_b), .mdio_out(out_b), .mdio_oe(oe_b), .rd_data(rd_b), .data_rdy(rdy_b),
        .done(done_b), .err(err_b), .busy(busy_b)
    );

    assign o_mdc  = sel ? mdc_b  : mdc_a;
    assign o_out  = sel ? out_b  : out_a;
    assign o_oe   = sel ? oe_b   : oe_a;
    assign o_rdy  = sel ? rdy_b  : rdy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_err  = sel ? err_b  : err_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_rd   = sel ? rd_b   : rd_a;

    // Runs one frame on the selected instance, checking every cycle against the bit-timing model.
    task automatic run_frame(input logic use_b, input logic [31:0] data, input logic [15:0] phy,
                             input logic pre_started, input logic hold,
                             input logic [31:0] next_data, input string name);
        int div, pre, n, b, fb, wave_bad, ctrl_bad, first_k;
        logic rd_op, exp_mdc, exp_oe, exp_out;
        sel = use_b;
        div = use_b ? 1 : 2;
        pre = use_b ? 0 : 32;
        n = (pre + 32) * 2 * div;
        rd_op = (data[31:30] == 2'b01) && (data[29:28] == 2'b10);
        if (!pre_started) begin
            @(negedge clk);
            t_data = data;
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
        end
        @(posedge clk);
        wave_bad = 0;
        ctrl_bad = 0;
        first_k = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (hold) begin
                t_data = next_data;
            end else begin
                if (use_b) start_b = 1'b0; else start_a = 1'b0;
            end
            b = (k - 1) / (2 * div);
            exp_mdc = ((k - 1) % (2 * div)) >= div;
            if (b < pre) begin
                exp_oe = 1'b1;
                exp_out = 1'b1;
                mdio_in = 1'b1;
            end else begin
                fb = 31 - (b - pre);
                exp_oe = !rd_op || (fb >= 18);
                exp_out = exp_oe && data[fb];
                if (fb <= 15) mdio_in = phy[fb];
                else mdio_in = 1'b1;
            end
            if (o_mdc !== exp_mdc || o_out !== exp_out || o_oe !== exp_oe) begin
                wave_bad++;
                if (first_k == 0) first_k = k;
            end
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_rdy !== 1'b0 || o_err !== 1'b0) ctrl_bad++;
        end
        total++;
        if (wave_bad !== 0) begin
            bad++;
            $display("[TB] FAIL %s wave: %0d wrong cycles (first at cycle %0d), required 0", name, wave_bad, first_k);
        end
        total++;
        if (ctrl_bad !== 0) begin
            bad++;
            $display("[TB] FAIL %s ctrl: %0d cycles with wrong busy/done/data_rdy/err, required 0", name, ctrl_bad);
        end
        @(negedge clk);
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_mdc !== 1'b0 || o_oe !== 1'b0 || o_out !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s done_cycle: done=%b busy=%b mdc=%b oe=%b out=%b, required 1 1 0 0 0",
                     name, o_done, o_busy, o_mdc, o_oe, o_out);
        end
        total++;
        if (o_rdy !== rd_op) begin
            bad++;
            $display("[TB] FAIL %s data_rdy: got %b, required %b", name, o_rdy, rd_op);
        end
        if (rd_op) begin
            total++;
            if (o_rd !== phy) begin
                bad++;
                $display("[TB] FAIL %s rd_data: got %h, required %h", name, o_rd, phy);
            end
        end
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rdy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s release: busy=%b done=%b data_rdy=%b, required 0 0 0", name, o_busy, o_done, o_rdy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({mdc_a, out_a, oe_a, rdy_a, done_a, err_a, busy_a, rd_a} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_a: outputs %h, required 0", {mdc_a, out_a, oe_a, rdy_a, done_a, err_a, busy_a, rd_a});
        end
        total++;
        if ({mdc_b, out_b, oe_b, rdy_b, done_b, err_b, busy_b, rd_b} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_b: outputs %h, required 0", {mdc_b, out_b, oe_b, rdy_b, done_b, err_b, busy_b, rd_b});
        end
        reset = 1'b0;
    endtask

    task automatic test_read;
        run_frame(1'b0, 32'h61840000, 16'h1234, 1'b0, 1'b0, 32'h0, "read");
    endtask

    task automatic test_write;
        run_frame(1'b0, 32'h508AABCD, 16'h0000, 1'b0, 1'b0, 32'h0, "write");
        total++;
        if (rd_a !== 16'h1234) begin
            bad++;
            $display("[TB] FAIL write_rd_hold: got %h, required 1234", rd_a);
        end
    endtask

    task automatic test_illegal(input logic [31:0] data, input string name);
        int errs;
        sel = 1'b0;
        @(negedge clk);
        t_data = data;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        total++;
        if (err_a !== 1'b1 || busy_a !== 1'b0 || mdc_a !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s err_pulse: err=%b busy=%b mdc=%b, required 1 0 0", name, err_a, busy_a, mdc_a);
        end
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (err_a !== 1'b0 || busy_a !== 1'b0 || mdc_a !== 1'b0 || oe_a !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("[TB] FAIL %s quiet: %0d cycles with activity, required 0", name, errs);
        end
    endtask

    task automatic test_back_to_back;
        run_frame(1'b0, 32'h508AABCD, 16'h0000, 1'b0, 1'b1, 32'h61840000, "b2b_first");
        run_frame(1'b0, 32'h61840000, 16'hBEEF, 1'b1, 1'b0, 32'h0, "b2b_second");
    endtask

    task automatic test_reset_abort;
        int act;
        sel = 1'b0;
        @(negedge clk);
        t_data = 32'h61840000;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (170) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({mdc_a, out_a, oe_a, rdy_a, done_a, err_a, busy_a, rd_a} !== 23'd0) begin
            bad++;
            $display("[TB] FAIL abort_outputs: %h, required 0", {mdc_a, out_a, oe_a, rdy_a, done_a, err_a, busy_a, rd_a});
        end
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || rdy_a !== 1'b0 || busy_a !== 1'b0 || mdc_a !== 1'b0) act++;
        end
        total++;
        if (act !== 0) begin
            bad++;
            $display("[TB] FAIL abort_idle: %0d active cycles, required 0", act);
        end
        run_frame(1'b0, 32'h61840000, 16'h0F0F, 1'b0, 1'b0, 32'h0, "read_after_abort");
    endtask

    task automatic test_fast_div;
        run_frame(1'b1, 32'h61840000, 16'hA5C3, 1'b0, 1'b0, 32'h0, "fast_read");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_illegal(32'h40000000, "illegal_op");
        test_illegal(32'h0C000000, "illegal_st");
        test_back_to_back();
        test_reset_abort();
        test_fast_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
